sync_fifo_prog: RTL and testbench

//   Single-clock, parametrised FIFO for buffering within one clock domain of the SDR datapath.

---
 rtl/sdr_fifo_pkg.sv | 30 +++
 rtl/fifo_mem_2p.sv | 30 +++
 rtl/sync_fifo_prog.sv | 143 ++++++++++++++
 tb/tb_sync_fifo_prog.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_fifo_pkg.sv
// Shared FIFO helpers: clog2, occupancy-count width and flag reset values.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdr_fifo_pkg;

    // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Occupancy counter needs one extra bit so that it can hold DEPTH itself
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Flag values after reset or flush (an empty FIFO)
    localparam logic FLAG_EMPTY_RST  = 1'b1;
    localparam logic FLAG_FULL_RST   = 1'b0;
    localparam logic FLAG_AEMPTY_RST = 1'b1;
    localparam logic FLAG_AFULL_RST  = 1'b0;
    localparam logic FLAG_ERR_RST    = 1'b0;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module fifo_mem_2p
    import sdr_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky errors, flush, optional FWFT.
// Latency: FWFT=0 read data 1 clock after accepted rd_en; FWFT=1 head word visible 1 clock after write.
// Backpressure: writes while full are dropped (overflow), reads while empty ignored (underflow).
module sync_fifo_prog
    import sdr_fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_unf;
    logic [WIDTH-1:0]  r_dout;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0]  w_rd_dat;

    // Flush suppresses both ports so neither the pointers nor the sticky flags move
    assign w_wr_acc = wr_en && !r_full  && !flush;
    assign w_rd_acc = rd_en && !r_empty && !flush;

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdat  (din),
        .i_raddr (r_rd_ptr),
        .o_rdat  (w_rd_dat)
    );

    // Next occupancy; simultaneous accepted read and write cancel out
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Pointers, count and count-derived flags, all registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= FLAG_FULL_RST;
            r_empty  <= FLAG_EMPTY_RST;
            r_afull  <= FLAG_AFULL_RST;
            r_aempty <= FLAG_AEMPTY_RST;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= FLAG_FULL_RST;
            r_empty  <= FLAG_EMPTY_RST;
            r_afull  <= FLAG_AFULL_RST;
            r_aempty <= FLAG_AEMPTY_RST;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty  <= (w_cnt_nxt == '0);
            r_afull  <= (w_cnt_nxt >= CNT_W'(AFULL_THRESH));
            r_aempty <= (w_cnt_nxt <= CNT_W'(AEMPTY_THRESH));
        end
    end

    // Sticky error flags; rejected requests during flush do not count as errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= FLAG_ERR_RST;
            r_unf <= FLAG_ERR_RST;
        end else if (flush) begin
            r_ovf <= FLAG_ERR_RST;
            r_unf <= FLAG_ERR_RST;
        end else begin
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Registered read data for the standard (non-FWFT) mode; holds across flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rd_dat;
        end
    end

    // FWFT exposes the head word directly and forces zero while empty
    assign dout         = (FWFT != 0) ? (r_empty ? '0 : w_rd_dat) : r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;

    // Standard-read instance
    logic        flush, wr_en, rd_en;
    logic [31:0] din, dout;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    // FWFT instance
    logic        f_flush, f_wr_en, f_rd_en;
    logic [31:0] f_din, f_dout;
    logic        f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0]  f_count;

    int n_chk;
    int n_fail;

    sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (f_flush),
        .din          (f_din),
        .wr_en        (f_wr_en),
        .rd_en        (f_rd_en),
        .dout         (f_dout),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0; wr_en   = 1'b0; rd_en   = 1'b0; din   = '0;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = '0;

        // 1. Reset values
        #100;
        chk("rst_empty",   64'(empty),        64'd1);
        chk("rst_full",    64'(full),         64'd0);
        chk("rst_aempty",  64'(almost_empty), 64'd1);
        chk("rst_afull",   64'(almost_full),  64'd0);
        chk("rst_count",   64'(count),        64'd0);
        chk("rst_dout",    64'(dout),         64'd0);
        chk("rst_ovf",     64'(overflow),     64'd0);
        chk("rst_unf",     64'(underflow),    64'd0);
        chk("rst_f_dout",  64'(f_dout),       64'd0);
        chk("rst_f_empty", 64'(f_empty),      64'd1);
        rst_n = 1'b1;
        tick();

        // 2. Fill 0..15, overflow on a 17th write, drain in order
        for (int i = 0; i < 16; i++) begin
            din = 32'(i); wr_en = 1'b1;
            tick();
            chk("fill_count", 64'(count), 64'(i + 1));
            chk("fill_afull", 64'(almost_full), ((i + 1) >= 14) ? 64'd1 : 64'd0);
            chk("fill_full",  64'(full), ((i + 1) == 16) ? 64'd1 : 64'd0);
            chk("fill_empty", 64'(empty), 64'd0);
        end
        din = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("ovf_count", 64'(count),    64'd16);
        chk("ovf_flag",  64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_dout",   64'(dout), 64'(i));
            chk("drain_count",  64'(count), 64'(15 - i));
            chk("drain_aempty", 64'(almost_empty), ((15 - i) <= 2) ? 64'd1 : 64'd0);
        end
        rd_en = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_full",  64'(full),  64'd0);

        // 3. Prefill 8, then 20 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 8; i++) begin
            din = 32'(100 + i); wr_en = 1'b1;
            tick();
        end
        chk("pre_count", 64'(count), 64'd8);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 32'(108 + k);
            tick();
            chk("rw_dout",  64'(dout),  64'(100 + k));
            chk("rw_count", 64'(count), 64'd8);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rw_tail", 64'(dout), 64'(120 + k));
        end
        rd_en = 1'b0;
        chk("rw_empty", 64'(empty), 64'd1);

        // 4. Underflow, then flush clears both sticky flags
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_flag",  64'(underflow), 64'd1);
        chk("unf_dout",  64'(dout),      64'd127);
        chk("unf_count", 64'(count),     64'd0);
        chk("unf_ovf",   64'(overflow),  64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_unf",  64'(underflow), 64'd0);
        chk("flush_ovf",  64'(overflow),  64'd0);
        chk("flush_dout", 64'(dout),      64'd127);

        // 5. FWFT: head word appears without rd_en, pop empties
        f_din = 32'hA5A5A5A5; f_wr_en = 1'b1;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_empty", 64'(f_empty), 64'd0);
        chk("fwft_dout",  64'(f_dout),  64'hA5A5A5A5);
        tick();
        chk("fwft_hold",  64'(f_dout),  64'hA5A5A5A5);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fwft_pop_empty", 64'(f_empty), 64'd1);
        chk("fwft_pop_dout",  64'(f_dout),  64'd0);
        f_wr_en = 1'b1; f_din = 32'h11;
        tick();
        f_din = 32'h22;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_head1", 64'(f_dout), 64'h11);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        chk("fwft_head2", 64'(f_dout),  64'h22);
        chk("fwft_cnt",   64'(f_count), 64'd1);

        // 6a. Flush at count=5 with a write pending
        for (int i = 0; i < 5; i++) begin
            din = 32'(200 + i); wr_en = 1'b1;
            tick();
        end
        chk("f6_count5", 64'(count), 64'd5);
        din = 32'hBEEF; flush = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("f6_count", 64'(count),    64'd0);
        chk("f6_empty", 64'(empty),    64'd1);
        chk("f6_ovf",   64'(overflow), 64'd0);
        din = 32'h77; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("f6_after", 64'(dout), 64'h77);

        // 6b. Asynchronous reset at count=10, checked before any clock edge
        for (int i = 0; i < 10; i++) begin
            din = 32'(300 + i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        chk("ar_count10", 64'(count), 64'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count",  64'(count),        64'd0);
        chk("ar_empty",  64'(empty),        64'd1);
        chk("ar_aempty", 64'(almost_empty), 64'd1);
        chk("ar_dout",   64'(dout),         64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        din = 32'h55; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("ar_first",  64'(dout),  64'h55);
        chk("ar_empty2", 64'(empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
